// File: rtl/wb_ddr_arbiter.sv
// rtl/wb_ddr_arbiter.sv - two-master round-robin Wishbone arbiter in front of the DDR controller, with bus watchdog
module wb_ddr_arbiter #(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int timeout   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,

    // master 0 (instruction bus)
    input  logic                   m0_cyc,
    input  logic                   m0_stb,
    input  logic                   m0_we,
    input  logic [dat_width/8-1:0] m0_sel,
    input  logic [adr_width-1:0]   m0_adr,
    input  logic [dat_width-1:0]   m0_dat_w,
    output logic [dat_width-1:0]   m0_dat_r,
    output logic                   m0_ack,
    output logic                   m0_err,

    // master 1 (data bus)
    input  logic                   m1_cyc,
    input  logic                   m1_stb,
    input  logic                   m1_we,
    input  logic [dat_width/8-1:0] m1_sel,
    input  logic [adr_width-1:0]   m1_adr,
    input  logic [dat_width-1:0]   m1_dat_w,
    output logic [dat_width-1:0]   m1_dat_r,
    output logic                   m1_ack,
    output logic                   m1_err,

    // shared slave (DDR controller)
    output logic                   s_cyc,
    output logic                   s_stb,
    output logic                   s_we,
    output logic [dat_width/8-1:0] s_sel,
    output logic [adr_width-1:0]   s_adr,
    output logic [dat_width-1:0]   s_dat_w,
    input  logic [dat_width-1:0]   s_dat_r,
    input  logic                   s_ack,
    input  logic                   s_err
);

    localparam int cnt_width = $clog2(timeout) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // last = index of the master most recently granted; the other one wins a tie
    logic   last;
    logic   last_nxt;

    // cyc/stb of whichever master currently owns the slave (0 in IDLE)
    logic   gnt_cyc;
    logic   gnt_stb;
    logic   wdog_fire;

    // State and round-robin pointer register; reset leaves m0 as the first tie winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: arbitrate from IDLE, hold grant while owner keeps cyc, hand over without a bubble
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_nxt = GNT0;
                end else if (m1_cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs: mux the granted master onto the slave and route ack/err back to it only
    always_comb begin
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        case (state)
            GNT0: begin
                gnt_cyc = m0_cyc;
                gnt_stb = m0_stb;
                s_we    = m0_we;
                s_sel   = m0_sel;
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
            end
            GNT1: begin
                gnt_cyc = m1_cyc;
                gnt_stb = m1_stb;
                s_we    = m1_we;
                s_sel   = m1_sel;
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
            end
            default: begin
                gnt_cyc = 1'b0;
                gnt_stb = 1'b0;
            end
        endcase

        s_cyc  = gnt_cyc;
        // a firing watchdog withdraws the strobe so the slave sees the access abandoned
        s_stb  = gnt_stb & ~wdog_fire;

        m0_ack = (state == GNT0) & s_ack & s_cyc;
        m1_ack = (state == GNT1) & s_ack & s_cyc;
        m0_err = (state == GNT0) & ((s_err & s_cyc) | wdog_fire);
        m1_err = (state == GNT1) & ((s_err & s_cyc) | wdog_fire);
    end

    // read data is broadcast; each master qualifies it with its own ack
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

    generate
        if (timeout == 0) begin : g_no_wdog
            assign wdog_fire = 1'b0;
        end else begin : g_wdog
            localparam logic [cnt_width-1:0] fire_cnt = cnt_width'(timeout - 1);

            logic [cnt_width-1:0] wdog_cnt;

            // Watchdog counter: counts strobed cycles with no slave response, saturating, cleared otherwise
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wdog_cnt <= '0;
                end else if (state == IDLE || s_ack || s_err || wdog_fire || !(s_cyc && s_stb)) begin
                    wdog_cnt <= '0;
                end else if (wdog_cnt != {cnt_width{1'b1}}) begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
            end

            // a slave response in the final cycle takes precedence over the forced error
            assign wdog_fire = gnt_cyc & gnt_stb & ~s_ack & ~s_err & (wdog_cnt == fire_cnt);
        end
    endgenerate

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// tb/tb_wb_ddr_arbiter.sv - directed self-checking bench for wb_ddr_arbiter
module tb_wb_ddr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_cyc, m0_stb, m0_we;
    logic [3:0]    m0_sel;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat_w, m0_dat_r;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [3:0]    m1_sel;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat_w, m1_dat_r;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic          s_ack, s_err;

    int vectors = 0;
    int errors  = 0;

    wb_ddr_arbiter #(.adr_width(AW), .dat_width(DW), .timeout(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
        .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
        .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = '0; m0_dat_w = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hF; m1_adr = '0; m1_dat_w = '0;
        s_dat_r = '0; s_ack = 0; s_err = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #3;
        vectors++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin errors++; $display("FAIL reset_slave_ctl got %b exp 000", {s_cyc, s_stb, s_we}); end
        vectors++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin errors++; $display("FAIL reset_master_resp got %b exp 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        step();
        reset = 1'b0;
        step(); #1;
        vectors++; if ({s_cyc, s_stb} !== 2'b00 || s_adr !== '0) begin errors++; $display("FAIL idle_outputs cyc/stb=%b adr=%h exp 00 0", {s_cyc, s_stb}, s_adr); end
    endtask

    task automatic test_single_read;
        do_reset();
        m0_adr = 32'h4000_0000; m0_we = 0; m0_cyc = 1; m0_stb = 1;
        #1;
        vectors++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rd_arb_latency s_cyc=%b exp 0", s_cyc); end
        step(); #1;
        vectors++; if ({s_cyc, s_stb} !== 2'b11) begin errors++; $display("FAIL rd_grant cyc/stb=%b exp 11", {s_cyc, s_stb}); end
        vectors++; if (s_adr !== 32'h4000_0000 || s_we !== 1'b0) begin errors++; $display("FAIL rd_adr adr=%h we=%b exp 40000000 0", s_adr, s_we); end
        for (int n = 0; n < 2; n++) begin
            vectors++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL rd_wait%0d acks=%b exp 00", n, {m0_ack, m1_ack}); end
            step(); #1;
        end
        s_ack = 1; s_dat_r = 32'hDEAD_BEEF; #1;
        vectors++; if (m0_ack !== 1'b1 || m0_dat_r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_ack ack=%b dat=%h exp 1 deadbeef", m0_ack, m0_dat_r); end
        vectors++; if ({m1_ack, m0_err} !== 2'b00) begin errors++; $display("FAIL rd_other m1_ack/m0_err=%b exp 00", {m1_ack, m0_err}); end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
        vectors++; if ({m0_ack, s_cyc} !== 2'b00) begin errors++; $display("FAIL rd_end ack/cyc=%b exp 00", {m0_ack, s_cyc}); end
    endtask

    task automatic test_round_robin;
        do_reset();
        m0_adr = 32'h100; m1_adr = 32'h200;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        step(); #1;
        vectors++; if (s_cyc !== 1'b1 || s_adr !== 32'h100) begin errors++; $display("FAIL rr_first cyc=%b adr=%h exp 1 100", s_cyc, s_adr); end
        s_ack = 1; #1;
        vectors++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL rr_m0_ack acks=%b exp 10", {m0_ack, m1_ack}); end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
        vectors++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_release s_cyc=%b exp 0", s_cyc); end
        step(); #1;
        vectors++; if (s_cyc !== 1'b1 || s_adr !== 32'h200) begin errors++; $display("FAIL rr_handover cyc=%b adr=%h exp 1 200", s_cyc, s_adr); end
        s_ack = 1; #1;
        vectors++; if ({m0_ack, m1_ack} !== 2'b01) begin errors++; $display("FAIL rr_m1_ack acks=%b exp 01", {m0_ack, m1_ack}); end
        step();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        step(); #1;
        vectors++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_idle s_cyc=%b exp 0", s_cyc); end
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        step(); #1;
        vectors++; if (s_adr !== 32'h100) begin errors++; $display("FAIL rr_second_tie adr=%h exp 100", s_adr); end
        m0_cyc = 0; m0_stb = 0;
        step(); #1;
        vectors++; if (s_cyc !== 1'b1 || s_adr !== 32'h200) begin errors++; $display("FAIL rr_alternate cyc=%b adr=%h exp 1 200", s_cyc, s_adr); end
        m1_cyc = 0; m1_stb = 0;
        step();
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_adr;
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h10; m1_dat_w = 32'hA0;
        step();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            exp_adr = 32'h10 + i;
            m1_adr = exp_adr; m1_dat_w = 32'hA0 + i; s_ack = 1; #1;
            vectors++; if (s_adr !== exp_adr || s_dat_w !== 32'hA0 + i || s_we !== 1'b1) begin errors++; $display("FAIL b2b_beat%0d adr=%h dat=%h we=%b exp %h %h 1", i, s_adr, s_dat_w, s_we, exp_adr, 32'hA0 + i); end
            vectors++; if ({m1_ack, m0_ack} !== 2'b10) begin errors++; $display("FAIL b2b_ack%0d m1/m0=%b exp 10", i, {m1_ack, m0_ack}); end
            step();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; #1;
        vectors++; if ({s_cyc, m0_ack} !== 2'b00) begin errors++; $display("FAIL b2b_release cyc/m0_ack=%b exp 00", {s_cyc, m0_ack}); end
        step();
        s_ack = 1; #1;
        vectors++; if (m0_ack !== 1'b1 || s_adr !== 32'h300) begin errors++; $display("FAIL b2b_m0_after ack=%b adr=%h exp 1 300", m0_ack, s_adr); end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step();
    endtask

    task automatic test_watchdog;
        int   fire_at;
        logic stb_at;
        logic m0_err_seen;
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h500;
        step();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600;
        fire_at = -1; stb_at = 1'bx; m0_err_seen = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (m0_err !== 1'b0) m0_err_seen = 1;
            if (m1_err === 1'b1) begin
                fire_at = n; stb_at = s_stb;
                break;
            end
            step();
        end
        vectors++; if (fire_at != TO - 1) begin errors++; $display("FAIL wdog_fire_cycle got %0d exp %0d", fire_at, TO - 1); end
        vectors++; if (stb_at !== 1'b0) begin errors++; $display("FAIL wdog_stb_mask s_stb=%b exp 0", stb_at); end
        vectors++; if (m0_err_seen !== 1'b0) begin errors++; $display("FAIL wdog_ungranted m0_err seen=%b exp 0", m0_err_seen); end
        step(); #1;
        vectors++; if ({m1_err, s_stb} !== 2'b01) begin errors++; $display("FAIL wdog_one_cycle err/stb=%b exp 01", {m1_err, s_stb}); end
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        step();
        s_ack = 1; #1;
        vectors++; if ({m0_ack, m0_err} !== 2'b10 || s_adr !== 32'h600) begin errors++; $display("FAIL wdog_m0_after ack/err=%b adr=%h exp 10 600", {m0_ack, m0_err}, s_adr); end
        step();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step();
    endtask

    task automatic test_ack_at_limit;
        logic err_seen;
        int   fire_at;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h700;
        step();
        err_seen = 0;
        for (int n = 0; n < TO - 1; n++) begin
            #1;
            if (m0_err !== 1'b0) err_seen = 1;
            step();
        end
        s_ack = 1; s_dat_r = 32'h1234_5678; #1;
        vectors++; if (err_seen !== 1'b0) begin errors++; $display("FAIL lim_early_err seen=%b exp 0", err_seen); end
        vectors++; if ({m0_ack, m0_err, s_stb} !== 3'b101) begin errors++; $display("FAIL lim_ack_wins ack/err/stb=%b exp 101", {m0_ack, m0_err, s_stb}); end
        step();
        s_ack = 0;
        fire_at = -1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (m0_err === 1'b1) begin
                fire_at = n;
                break;
            end
            step();
        end
        vectors++; if (fire_at != TO - 1) begin errors++; $display("FAIL lim_counter_cleared fire at %0d exp %0d", fire_at, TO - 1); end
        m0_cyc = 0; m0_stb = 0;
        step();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h800;
        step();
        s_ack = 1; #1;
        vectors++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL mid_burst_ack ack=%b exp 1", m0_ack); end
        step();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h900;
        #1 reset = 1'b1;
        #1;
        vectors++; if ({s_cyc, s_stb, s_we, m0_ack, m1_ack} !== 5'b00000) begin errors++; $display("FAIL async_reset cyc/stb/we/acks=%b exp 00000", {s_cyc, s_stb, s_we, m0_ack, m1_ack}); end
        reset = 1'b0; s_ack = 0;
        #1;
        vectors++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL post_reset_idle s_cyc=%b exp 0", s_cyc); end
        step(); #1;
        vectors++; if (s_cyc !== 1'b1 || s_adr !== 32'h800) begin errors++; $display("FAIL post_reset_tie cyc=%b adr=%h exp 1 800", s_cyc, s_adr); end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_watchdog();
        test_ack_at_limit();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
